// File: rtl/gcd.sv
// gcd: iterative subtract-and-compare Euclid engine, one step per clock.
// Define GCD_CLEAR_ON_LOAD_EN to zero gcd_out on the load edge.
module gcd (
  input  logic       clk,
  input  logic       clr,
  input  logic       go,
  input  logic [7:0] xin,
  input  logic [7:0] yin,
  output logic [7:0] gcd_out
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [7:0] x, y;
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      gcd_out <= '0;
    end else begin
      case (state)
        IDLE: if (go) begin
          x     <= xin;
          y     <= yin;
          state <= CALC;
`ifdef GCD_CLEAR_ON_LOAD_EN
          gcd_out <= '0;
`else
          gcd_out <= gcd_out;
`endif
        end
        CALC: if (x == '0) begin
          gcd_out <= y;
          state   <= DONE;
        end else if (y == '0 || x == y) begin
          gcd_out <= x;
          state   <= DONE;
        end else if (x < y) begin
          y <= y - x;
        end else begin
          x <= x - y;
        end
        DONE: if (!go) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gcd.sv
// tb_gcd: directed vectors; stimulus queues expected results, a monitor checks them.
module tb_gcd;
  logic clk = 1'b0, clr = 1'b0, go = 1'b0;
  logic [7:0] xin = '0, yin = '0, gcd_out;
  int tests = 0, fails = 0, issued = 0, checked = 0;
  logic [7:0] last_res = '0;
  typedef struct {
    logic [7:0] exp;
    logic [7:0] pre;
    int lat;
    string name;
  } item_t;
  item_t q[$];

  gcd dut (.clk(clk), .clr(clr), .go(go), .xin(xin), .yin(yin), .gcd_out(gcd_out));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: for each queued load, output must hold its pre-load value until
  // exactly the expected edge, where the result must appear.
  initial begin
    item_t it;
    forever begin
      wait (q.size() > 0);
      it = q.pop_front();
      for (int i = 1; i <= it.lat; i++) begin
        @(posedge clk);
        #1;
        if (i < it.lat) check({it.name, " pre"}, gcd_out, it.pre);
        else check({it.name, " result"}, gcd_out, it.exp);
      end
      checked++;
    end
  end

  task automatic pulse_clr;
    @(negedge clk);
    clr = 1'b1;
    go  = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    last_res = '0;
  endtask

  // Drop go for one cycle, then load; the load edge follows.
  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp,
                     input int lat, input string name);
    item_t it;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    go  = 1'b1;
    xin = a;
    yin = b;
    @(posedge clk);
`ifdef GCD_CLEAR_ON_LOAD_EN
    it.pre = '0;
`else
    it.pre = last_res;
`endif
    it.exp  = exp;
    it.lat  = lat;
    it.name = name;
    q.push_back(it);
    issued++;
    last_res = exp;
    @(negedge clk);
    xin = ~a;
    yin = ~b;
    repeat (lat) @(posedge clk);
    #2;
  endtask

  task automatic hold(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check(name, gcd_out, last_res);
    end
  endtask

  initial begin
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    #1 check("reset", gcd_out, 8'd0);
    hold(3, "idle no go");
    pulse_clr();
    run(8'd3, 8'd6, 8'd3, 2, "3_6");
    hold(10, "3_6 hold");
    pulse_clr();
    run(8'd49, 8'd35, 8'd7, 5, "49_35");
    hold(5, "49_35 hold");
    run(8'd0, 8'd9, 8'd9, 1, "0_9");
    run(8'd0, 8'd0, 8'd0, 1, "0_0");
    run(8'd13, 8'd13, 8'd13, 1, "13_13");
    run(8'd255, 8'd1, 8'd1, 255, "255_1");
    hold(3, "255_1 hold");
    // Abort (200,3) mid-computation.
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    go  = 1'b1;
    xin = 8'd200;
    yin = 8'd3;
    repeat (10) @(posedge clk);
    #1;
`ifdef GCD_CLEAR_ON_LOAD_EN
    check("200_3 mid", gcd_out, 8'd0);
`else
    check("200_3 mid", gcd_out, 8'd1);
`endif
    @(negedge clk);
    clr = 1'b1;
    go  = 1'b0;
    @(posedge clk);
    #1 check("mid clr", gcd_out, 8'd0);
    @(negedge clk);
    clr = 1'b0;
    last_res = '0;
    hold(4, "after clr idle");
    run(8'd12, 8'd18, 8'd6, 3, "12_18");
    hold(3, "12_18 hold");
    run(8'd100, 8'd75, 8'd25, 4, "100_75");
    hold(4, "100_75 hold");
    repeat (3) @(posedge clk);
    tests++;
    if (checked != issued || q.size() != 0) begin
      fails++;
      $display("FAIL monitor: checked %0d of %0d issued", checked, issued);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/gcd.md
# gcd

Iterative greatest-common-divisor engine for two 8-bit unsigned operands. On a `go` request it captures `xin` and `yin`, then runs the subtract-and-compare Euclid algorithm at one step per clock. It drives the result on `gcd_out` and holds it there. It is a self-contained datapath plus FSM block, used wherever a small, slow, area-cheap GCD unit is needed.

## Interface
- No parameters; operand and result width is fixed at 8 bits.
- One clock; reset is synchronous and active-high.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `clr` input, 1 bit: synchronous, active-high reset.
- `go` input, 1 bit: start request, level-sampled in IDLE.
- `xin` input, 8 bits: first operand, unsigned.
- `yin` input, 8 bits: second operand, unsigned.
- `gcd_out` output, 8 bits: registered result.

## Operation
- Internal registers:
  - `x` and `y` (8 bits each).
  - `state` with three states: IDLE, CALC, DONE.
- IDLE:
  - If `go`=1, load `x`←`xin`, `y`←`yin` and go to CALC.
  - Otherwise stay in IDLE.
- CALC evaluates exactly one of the following per cycle, in this priority:
  - `x`==0: `gcd_out`←`y`, go to DONE.
  - `y`==0: `gcd_out`←`x`, go to DONE.
  - `x`==`y`: `gcd_out`←`x`, go to DONE.
  - `x`<`y`: `y`←`y`−`x`, stay in CALC.
  - Otherwise: `x`←`x`−`y`, stay in CALC.
- Arithmetic rules:
  - All comparisons are unsigned 8-bit.
  - Subtraction always takes the larger operand minus the smaller, so it never underflows.
  - No operand widening is needed.
- DONE:
  - `gcd_out` is held.
  - Stay in DONE while `go`=1.
  - Return to IDLE when `go`=0.
  - A new computation requires `go` to be low for at least one cycle, or a `clr`.
- Zero operands: gcd(0,n)=n and gcd(0,0)=0. The block terminates and never hangs.
- `xin` and `yin` are sampled only on the load edge. Changes during CALC or DONE are ignored.

## Timing
- `clr`=1 at a rising edge has priority over everything, including mid-computation:
  - `state`←IDLE, `x`←0, `y`←0, `gcd_out`←0.
- Load edge: the first rising edge with `clr`=0, `go`=1, state IDLE.
- Latency from the load edge to `gcd_out` being valid is S+1 further edges, where S is the number of subtraction steps.
  - Example: (3,6) gives S=1, so the result is valid 2 edges after load.
  - Example: (49,35) gives S=4, so the result is valid 5 edges after load.
- Worst case is (255,1) or (1,255): 254 subtractions, result valid 255 edges after load.
- `gcd_out` changes only on the DONE-entry edge, or on `clr` (and on load, see Configuration). It is otherwise stable.
- `go` held high continuously after completion causes no restart.

## Configuration
- Macro `GCD_CLEAR_ON_LOAD_EN`:
  - Defined: `gcd_out`←0 on the load edge, so a stale result is never visible during CALC.
  - Undefined (default): `gcd_out` keeps the previous result until the new result is written on DONE entry.
- Reset behaviour is identical in both builds.

## Test plan
- `clr`=1 for one cycle -> `gcd_out`=0, FSM in IDLE, `go`=0 produces no activity.
- `clr` pulse, then `go`=1, `xin`=3, `yin`=6 held -> `gcd_out`=3 within 2 edges after load, then stable through 10 cycles.
- `clr` pulse, then `go`=1, `xin`=49, `yin`=35 -> `gcd_out`=7 exactly 5 edges after load, held while `go`=1.
- Operand cases:
  - (0,9) -> 9.
  - (0,0) -> 0.
  - (13,13) -> 13 one edge after load.
  - (255,1) -> 1 after 255 edges.
- `clr` asserted mid-CALC on (200,3) -> next edge `gcd_out`=0 and IDLE; a subsequent `go` with (12,18) -> 6.
- DONE with `go` dropped for one cycle, then `go`=1 with (100,75) -> 25. Check the stale-result behaviour against the `GCD_CLEAR_ON_LOAD_EN` setting.
